// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared RV32 widths, opcode and branch funct3 encodings.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [6:0] {
      OP_LOAD     = 7'b0000011,
      OP_MISC_MEM = 7'b0001111,
      OP_IMM      = 7'b0010011,
      OP_AUIPC    = 7'b0010111,
      OP_STORE    = 7'b0100011,
      OP_OP       = 7'b0110011,
      OP_LUI      = 7'b0110111,
      OP_BRANCH   = 7'b1100011,
      OP_JALR     = 7'b1100111,
      OP_JAL      = 7'b1101111,
      OP_SYSTEM   = 7'b1110011
   } opcode_e;

   // 010 and 011 are reserved encodings; they are named so every 3-bit value is a legal member.
   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_RSV2 = 3'b010,
      F3_RSV3 = 3'b011,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_branch_e;

   function automatic logic is_jump_op(input opcode_e op);
      return (op == OP_JAL) || (op == OP_JALR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_compare.sv
`default_nettype none
// ============================================================================
//  Module   : branch_compare
//  Purpose  : Combinational RV32 branch condition evaluation.
//  Revision : 1.0  initial release
// ============================================================================
module branch_compare
   import riscv_pkg::*;
(
   input  funct3_branch_e  funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            cond
);

   logic w_eq;
   logic w_lt;
   logic w_ltu;

   assign w_eq  = (a == b);
   assign w_lt  = ($signed(a) < $signed(b));
   assign w_ltu = (a < b);

   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = w_eq;
         F3_BNE:  cond = ~w_eq;
         F3_BLT:  cond = w_lt;
         F3_BGE:  cond = ~w_lt;
         F3_BLTU: cond = w_ltu;
         F3_BGEU: cond = ~w_ltu;
         default: cond = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_unit
//  Purpose  : Execute-stage branch/jump resolution with registered redirect copy.
//  Revision : 1.0  initial release
// ============================================================================
module branch_unit
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  funct3_branch_e  funct3,
   input  opcode_e         opcode,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target,
   output logic            is_jump,
   output logic            target_misaligned,
   output logic            branch_taken_q,
   output logic [XLEN-1:0] branch_target_q,
   output logic            is_jump_q
);

   logic            w_cond;
   logic            w_is_jalr;
   logic [XLEN-1:0] w_add_base;
   logic [XLEN-1:0] w_sum;

   branch_compare u_compare (
      .funct3 (funct3),
      .a      (rs1_data),
      .b      (rs2_data),
      .cond   (w_cond)
   );

   assign w_is_jalr  = (opcode == OP_JALR);
   assign is_jump    = is_jump_op(opcode);

   // One shared adder: JALR is register-relative, everything else PC-relative.
   assign w_add_base = w_is_jalr ? rs1_data : pc;
   assign w_sum      = w_add_base + imm;

   always_comb begin
      branch_target = w_sum;
      if (w_is_jalr) begin
         branch_target[0] = 1'b0;
      end
   end

   always_comb begin
      branch_taken = 1'b0;
      if (is_jump) begin
         branch_taken = 1'b1;
      end else if (opcode == OP_BRANCH) begin
         branch_taken = w_cond;
      end
   end

   assign target_misaligned = branch_taken & branch_target[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_taken_q  <= 1'b0;
         branch_target_q <= '0;
         is_jump_q       <= 1'b0;
      end else begin
         branch_taken_q  <= branch_taken;
         branch_target_q <= branch_target;
         is_jump_q       <= is_jump;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_unit
//  Purpose  : Self-checking bench for branch_unit with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_unit;
   import riscv_pkg::*;

   logic           clk;
   logic           rst;
   logic [31:0]    rs1_data;
   logic [31:0]    rs2_data;
   logic [31:0]    pc;
   logic [31:0]    imm;
   funct3_branch_e funct3;
   opcode_e        opcode;
   logic           branch_taken;
   logic [31:0]    branch_target;
   logic           is_jump;
   logic           target_misaligned;
   logic           branch_taken_q;
   logic [31:0]    branch_target_q;
   logic           is_jump_q;

   int n_checks = 0;
   int n_pass   = 0;

   branch_unit dut (
      .clk               (clk),
      .rst               (rst),
      .rs1_data          (rs1_data),
      .rs2_data          (rs2_data),
      .pc                (pc),
      .imm               (imm),
      .funct3            (funct3),
      .opcode            (opcode),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .is_jump           (is_jump),
      .target_misaligned (target_misaligned),
      .branch_taken_q    (branch_taken_q),
      .branch_target_q   (branch_target_q),
      .is_jump_q         (is_jump_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: returns {taken, target[31:0], is_jump, misaligned}.
   function automatic logic [34:0] model(input opcode_e op, input funct3_branch_e f3,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] p, input logic [31:0] im);
      int signed   sa = a;
      int signed   sb = b;
      longint      ua = longint'(a);
      longint      ub = longint'(b);
      logic        cond;
      logic        jump;
      logic        taken;
      logic [31:0] tgt;
      case (f3)
         F3_BEQ:  cond = (ua == ub);
         F3_BNE:  cond = (ua != ub);
         F3_BLT:  cond = (sa < sb);
         F3_BGE:  cond = (sa >= sb);
         F3_BLTU: cond = (ua < ub);
         F3_BGEU: cond = (ua >= ub);
         default: cond = 1'b0;
      endcase
      jump  = (op == OP_JAL) || (op == OP_JALR);
      taken = jump ? 1'b1 : ((op == OP_BRANCH) ? cond : 1'b0);
      if (op == OP_JALR) tgt = 32'((ua + longint'(im)) % 64'h1_0000_0000) & 32'hFFFF_FFFE;
      else               tgt = 32'((longint'(p) + longint'(im)) % 64'h1_0000_0000);
      return {taken, tgt, jump, taken & tgt[1]};
   endfunction

   task automatic drive(input opcode_e op, input funct3_branch_e f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] im);
      opcode = op; funct3 = f3; rs1_data = a; rs2_data = b; pc = p; imm = im;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(OP_JAL, F3_BEQ, 32'h0, 32'h0, 32'h100, 32'h8);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({branch_taken_q, branch_target_q, is_jump_q} !== 34'h0)
         $display("FAIL reset_q: got %0h expected 0", {branch_taken_q, branch_target_q, is_jump_q});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_beq();
      drive(OP_BRANCH, F3_BEQ, 32'h5, 32'h5, 32'h1000, 32'h10);
      #1;
      n_checks++;
      if ({branch_taken, branch_target, is_jump} !== {1'b1, 32'h0000_1010, 1'b0})
         $display("FAIL beq_equal: got t=%b tgt=%h j=%b expected t=1 tgt=00001010 j=0",
                  branch_taken, branch_target, is_jump);
      else n_pass++;
      rs2_data = 32'h6;
      #1;
      n_checks++;
      if ({branch_taken, branch_target, is_jump} !== {1'b0, 32'h0000_1010, 1'b0})
         $display("FAIL beq_unequal: got t=%b tgt=%h j=%b expected t=0 tgt=00001010 j=0",
                  branch_taken, branch_target, is_jump);
      else n_pass++;
   endtask

   task automatic test_signed_boundaries();
      drive(OP_BRANCH, F3_BLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0);
      #1;
      n_checks++;
      if (branch_taken !== 1'b1) $display("FAIL blt_signed: got %b expected 1", branch_taken);
      else n_pass++;
      funct3 = F3_BLTU;
      #1;
      n_checks++;
      if (branch_taken !== 1'b0) $display("FAIL bltu_unsigned: got %b expected 0", branch_taken);
      else n_pass++;
      drive(OP_BRANCH, F3_BGE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
      #1;
      n_checks++;
      if (branch_taken !== 1'b1) $display("FAIL bge_equal: got %b expected 1", branch_taken);
      else n_pass++;
      funct3 = F3_BGEU;
      #1;
      n_checks++;
      if (branch_taken !== 1'b1) $display("FAIL bgeu_equal: got %b expected 1", branch_taken);
      else n_pass++;
      funct3 = F3_BLT;
      #1;
      n_checks++;
      if (branch_taken !== 1'b0) $display("FAIL blt_equal: got %b expected 0", branch_taken);
      else n_pass++;
   endtask

   task automatic test_jalr();
      drive(OP_JALR, F3_BEQ, 32'h2003, 32'h0, 32'h500, 32'h4);
      #1;
      n_checks++;
      if ({branch_taken, branch_target, is_jump, target_misaligned} !== {1'b1, 32'h0000_2006, 1'b1, 1'b1})
         $display("FAIL jalr: got t=%b tgt=%h j=%b mis=%b expected t=1 tgt=00002006 j=1 mis=1",
                  branch_taken, branch_target, is_jump, target_misaligned);
      else n_pass++;
   endtask

   task automatic test_jal_wrap();
      drive(OP_JAL, F3_BNE, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
      #1;
      n_checks++;
      if ({branch_taken, branch_target, is_jump, target_misaligned} !== {1'b1, 32'h0000_0010, 1'b1, 1'b0})
         $display("FAIL jal_wrap: got t=%b tgt=%h j=%b mis=%b expected t=1 tgt=00000010 j=1 mis=0",
                  branch_taken, branch_target, is_jump, target_misaligned);
      else n_pass++;
   endtask

   task automatic test_non_control();
      drive(OP_IMM, F3_BEQ, 32'h7, 32'h7, 32'h300, 32'h2);
      #1;
      n_checks++;
      if ({branch_taken, branch_target, is_jump, target_misaligned} !== {1'b0, 32'h0000_0302, 1'b0, 1'b0})
         $display("FAIL op_imm: got t=%b tgt=%h j=%b mis=%b expected t=0 tgt=00000302 j=0 mis=0",
                  branch_taken, branch_target, is_jump, target_misaligned);
      else n_pass++;
      drive(OP_BRANCH, F3_RSV2, 32'h1, 32'h2, 32'h400, 32'h8);
      #1;
      n_checks++;
      if ({branch_taken, branch_target, is_jump} !== {1'b0, 32'h0000_0408, 1'b0})
         $display("FAIL branch_f3_010: got t=%b tgt=%h j=%b expected t=0 tgt=00000408 j=0",
                  branch_taken, branch_target, is_jump);
      else n_pass++;
      funct3 = F3_RSV3;
      #1;
      n_checks++;
      if (branch_taken !== 1'b0) $display("FAIL branch_f3_011: got %b expected 0", branch_taken);
      else n_pass++;
   endtask

   task automatic test_registered();
      @(negedge clk);
      drive(OP_JAL, F3_BEQ, 32'h0, 32'h0, 32'h0000_1234, 32'h0000_0100);
      @(posedge clk);
      #1;
      n_checks++;
      if ({branch_taken_q, branch_target_q, is_jump_q} !== {1'b1, 32'h0000_1334, 1'b1})
         $display("FAIL reg_capture: got t=%b tgt=%h j=%b expected t=1 tgt=00001334 j=1",
                  branch_taken_q, branch_target_q, is_jump_q);
      else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({branch_taken_q, branch_target_q, is_jump_q} !== 34'h0)
         $display("FAIL async_reset: got %0h expected 0", {branch_taken_q, branch_target_q, is_jump_q});
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if ({branch_taken_q, branch_target_q, is_jump_q} !== 34'h0)
         $display("FAIL reset_hold: got %0h expected 0", {branch_taken_q, branch_target_q, is_jump_q});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({branch_taken_q, branch_target_q, is_jump_q} !== {1'b1, 32'h0000_1334, 1'b1})
         $display("FAIL reg_after_reset: got t=%b tgt=%h j=%b expected t=1 tgt=00001334 j=1",
                  branch_taken_q, branch_target_q, is_jump_q);
      else n_pass++;
   endtask

   task automatic test_random();
      opcode_e     ops[3] = '{OP_BRANCH, OP_JAL, OP_JALR};
      logic [34:0] exp;
      logic [31:0] a;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a = $urandom;
         drive(ops[$urandom_range(0, 2)], funct3_branch_e'($urandom_range(0, 7)), a,
               ($urandom_range(0, 3) == 0) ? a : 32'($urandom), 32'($urandom), 32'($urandom));
         exp = model(opcode, funct3, rs1_data, rs2_data, pc, imm);
         #1;
         n_checks++;
         if ({branch_taken, branch_target, is_jump, target_misaligned} !== exp)
            $display("FAIL rand_comb[%0d]: op=%h f3=%h got %h expected %h", i, opcode, funct3,
                     {branch_taken, branch_target, is_jump, target_misaligned}, exp);
         else n_pass++;
         @(posedge clk);
         #1;
         n_checks++;
         if ({branch_taken_q, branch_target_q, is_jump_q} !== exp[34:1])
            $display("FAIL rand_reg[%0d]: got %h expected %h", i,
                     {branch_taken_q, branch_target_q, is_jump_q}, exp[34:1]);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(OP_IMM, F3_BEQ, 32'h0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_beq();
      test_signed_boundaries();
      test_jalr();
      test_jal_wrap();
      test_non_control();
      test_registered();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
